// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Round-robin arbiter sharing one data-memory port between two
//               requesters, with one outstanding access and optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic                 req0_write_enable,
    input  logic [DATA_SIZE-1:0] req0_write_data,
    output logic                 rsp0_valid,
    output logic [DATA_SIZE-1:0] rsp0_read_data,
    output logic                 rsp0_error,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic                 req1_write_enable,
    input  logic [DATA_SIZE-1:0] req1_write_data,
    output logic                 rsp1_valid,
    output logic [DATA_SIZE-1:0] rsp1_read_data,
    output logic                 rsp1_error,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_write_enable,
    output logic [DATA_SIZE-1:0] mem_write_data,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    input  logic [DATA_SIZE-1:0] mem_read_data,
    output logic                 busy,
    output logic                 grant
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ACCESS  = 2'd1;
    localparam logic [1:0] c_S_RESPOND = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_ptr;
    logic                 r_grant;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_SIZE-1:0] r_mem_wdata;
    logic                 r_err;
    logic [DATA_SIZE-1:0] r_rsp_data0;
    logic [DATA_SIZE-1:0] r_rsp_data1;
    logic                 w_any;
    logic                 w_winner;
    logic                 w_idle;
    logic                 w_respond;
    logic                 w_timeout;

    assign w_any     = req0_valid | req1_valid;
    // Contention is settled by the pointer; a lone requester always wins.
    assign w_winner  = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    assign w_idle    = (r_state == c_S_IDLE);
    assign w_respond = (r_state == c_S_RESPOND);

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout_en
            assign w_timeout = (r_state == c_S_ACCESS) & ~mem_ready & (r_cnt == c_CNT_LAST);
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:    if (w_any) w_state_next = c_S_ACCESS;
            c_S_ACCESS:  if (mem_ready || w_timeout) w_state_next = c_S_RESPOND;
            c_S_RESPOND: w_state_next = c_S_IDLE;
            default:     w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= 1'b0;
            r_grant     <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
            r_rsp_data0 <= '0;
            r_rsp_data1 <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_winner;
                        r_cnt       <= '0;
                        r_mem_addr  <= w_winner ? req1_addr : req0_addr;
                        r_mem_we    <= w_winner ? req1_write_enable : req0_write_enable;
                        r_mem_wdata <= w_winner ? req1_write_data : req0_write_data;
                    end
                end
                c_S_ACCESS: begin
                    if (mem_ready) begin
                        r_err <= 1'b0;
                        if (r_grant) r_rsp_data1 <= r_mem_we ? '0 : mem_read_data;
                        else         r_rsp_data0 <= r_mem_we ? '0 : mem_read_data;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_grant) r_rsp_data1 <= '0;
                        else         r_rsp_data0 <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_S_RESPOND: r_ptr <= ~r_grant;
                default: ;
            endcase
        end
    end

    assign req0_ready       = w_idle & w_any & ~w_winner;
    assign req1_ready       = w_idle & w_any & w_winner;
    assign rsp0_valid       = w_respond & ~r_grant;
    assign rsp1_valid       = w_respond & r_grant;
    assign rsp0_error       = rsp0_valid & r_err;
    assign rsp1_error       = rsp1_valid & r_err;
    assign rsp0_read_data   = r_rsp_data0;
    assign rsp1_read_data   = r_rsp_data1;
    assign mem_valid        = (r_state == c_S_ACCESS);
    assign mem_addr         = r_mem_addr;
    assign mem_write_enable = r_mem_we;
    assign mem_write_data   = r_mem_wdata;
    assign busy             = ~w_idle;
    assign grant            = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Directed bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_read_data = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error;
    logic [31:0] rsp0_read_data, rsp1_read_data, mem_addr, mem_write_data;
    logic        mem_write_enable, mem_valid, busy, grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_write_enable(req0_we), .req0_write_data(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_read_data(rsp0_read_data), .rsp0_error(rsp0_error),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_write_enable(req1_we), .req1_write_data(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_read_data(rsp1_read_data), .rsp1_error(rsp1_error),
        .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_read_data(mem_read_data), .busy(busy), .grant(grant)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p;
        return v1;
    endfunction

    // Transaction-level model: an accepted request occupies the memory for
    // m_age = 1..c_TO cycles, then one response cycle follows.
    logic        m_open, m_resp, m_port, m_ptr, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_data0, m_data1;
    int          m_age;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_open <= 1'b0; m_resp <= 1'b0; m_port <= 1'b0; m_ptr <= 1'b0;
            m_we <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_data0 <= '0; m_data1 <= '0; m_age <= 0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
            m_ptr  <= ~m_port;
        end else if (m_open) begin
            if (mem_ready) begin
                m_open <= 1'b0; m_resp <= 1'b0 | 1'b1; m_err <= 1'b0;
                if (m_port) m_data1 <= m_we ? 32'd0 : mem_read_data;
                else        m_data0 <= m_we ? 32'd0 : mem_read_data;
            end else if (m_age == c_TO) begin
                m_open <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1;
                if (m_port) m_data1 <= 32'd0;
                else        m_data0 <= 32'd0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (req0_valid || req1_valid) begin
            m_port  <= pick(req0_valid, req1_valid, m_ptr);
            m_open  <= 1'b1;
            m_age   <= 1;
            m_addr  <= pick(req0_valid, req1_valid, m_ptr) ? req1_addr  : req0_addr;
            m_we    <= pick(req0_valid, req1_valid, m_ptr) ? req1_we    : req0_we;
            m_wdata <= pick(req0_valid, req1_valid, m_ptr) ? req1_wdata : req0_wdata;
        end
    end

    logic e_free, e_win;
    always @(negedge clk) begin
        if (rst) begin
            e_free = !m_open && !m_resp && (req0_valid || req1_valid);
            e_win  = pick(req0_valid, req1_valid, m_ptr);
            check1("m_busy", busy, m_open || m_resp);
            check1("m_mem_valid", mem_valid, m_open);
            check1("m_req0_ready", req0_ready, e_free && !e_win);
            check1("m_req1_ready", req1_ready, e_free && e_win);
            check1("m_rsp0_valid", rsp0_valid, m_resp && !m_port);
            check1("m_rsp1_valid", rsp1_valid, m_resp && m_port);
            check1("m_rsp0_error", rsp0_error, m_resp && !m_port && m_err);
            check1("m_rsp1_error", rsp1_error, m_resp && m_port && m_err);
            check32("m_rsp0_data", rsp0_read_data, m_data0);
            check32("m_rsp1_data", rsp1_read_data, m_data1);
            if (m_open || m_resp) check1("m_grant", grant, m_port);
            if (m_open) begin
                check32("m_mem_addr", mem_addr, m_addr);
                check1("m_mem_we", mem_write_enable, m_we);
                check32("m_mem_wdata", mem_write_data, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_acc, cnt, first_cyc, last_cyc;
    logic seen;
    logic [3:0] ports;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_grant", grant, 1'b0);
        check1("rst_mem_valid", mem_valid, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_rsp0_data", rsp0_read_data, 32'h0);

        // Single read on port 0
        req0_valid = 1'b1; req0_addr = 32'h60; req0_we = 1'b0; #1;
        check1("t1_req0_ready", req0_ready, 1'b1);
        check1("t1_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; mem_ready = 1'b1; mem_read_data = 32'h19; #1;
        check1("t1_mem_valid", mem_valid, 1'b1);
        check32("t1_mem_addr", mem_addr, 32'h60);
        tick();
        mem_ready = 1'b0; #1;
        check1("t1_rsp0_valid", rsp0_valid, 1'b1);
        check32("t1_rsp0_data", rsp0_read_data, 32'h19);
        check1("t1_rsp1_valid", rsp1_valid, 1'b0);
        tick(); #1;
        check1("t1_rsp0_done", rsp0_valid, 1'b0);
        check32("t1_rsp0_hold", rsp0_read_data, 32'h19);

        // Write on port 1 with three wait cycles
        req1_valid = 1'b1; req1_addr = 32'h64; req1_we = 1'b1; req1_wdata = 32'd25; #1;
        check1("t2_req1_ready", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            check1("t2_mem_valid", mem_valid, 1'b1);
            check32("t2_mem_addr", mem_addr, 32'h64);
            check32("t2_mem_wdata", mem_write_data, 32'd25);
            check1("t2_mem_we", mem_write_enable, 1'b1);
            tick();
        end
        mem_ready = 1'b0; #1;
        check1("t2_rsp1_valid", rsp1_valid, 1'b1);
        check1("t2_rsp1_error", rsp1_error, 1'b0);
        check32("t2_rsp1_data", rsp1_read_data, 32'h0);
        tick();

        // Contention after reset, zero-wait memory
        rst = 1'b0; tick(); rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h100; req0_we = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h200; req1_we = 1'b0;
        mem_ready = 1'b1; mem_read_data = 32'hA5;
        n_acc = 0; first_cyc = 0; last_cyc = 0; ports = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                if (n_acc < 4) ports[n_acc] = req1_ready;
                if (n_acc == 0) first_cyc = c;
                else check32("t3_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                n_acc++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check32("t3_accepts", 32'(n_acc), 32'd4);
        check32("t3_first", 32'(first_cyc), 32'd0);
        check32("t3_order", 32'(ports), 32'b1010);
        // memory stays ready through idle: nothing may start
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check1("t6_idle_busy", busy, 1'b0);
            check1("t6_idle_rsp0", rsp0_valid, 1'b0);
        end
        mem_ready = 1'b0;

        // Timeout on port 0
        req0_valid = 1'b1; req0_addr = 32'h80; req0_we = 1'b0; #1;
        check1("t4_req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (rsp0_valid) seen = 1'b1;
            else begin
                if (mem_valid) cnt++;
                tick();
            end
        end
        check1("t4_rsp_seen", seen, 1'b1);
        check32("t4_valid_cycles", 32'(cnt), 32'd4);
        check1("t4_rsp0_error", rsp0_error, 1'b1);
        check32("t4_rsp0_data", rsp0_read_data, 32'h0);
        tick();
        req1_valid = 1'b1; req1_addr = 32'h90; req1_we = 1'b1; req1_wdata = 32'd7; #1;
        check1("t4_next_ready", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0; mem_ready = 1'b1; #1;
        check32("t4_next_addr", mem_addr, 32'h90);
        tick();
        mem_ready = 1'b0; #1;
        check1("t4_next_rsp", rsp1_valid, 1'b1);
        tick();

        // Reset mid-access
        req0_valid = 1'b1; req0_addr = 32'hC0; req0_we = 1'b0;
        tick();
        req0_valid = 1'b0; #2;
        check1("t5_pre_valid", mem_valid, 1'b1);
        rst = 1'b0; #1;
        check1("t5_mem_valid", mem_valid, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check1("t5_rsp0", rsp0_valid, 1'b0);
        check32("t5_mem_addr", mem_addr, 32'h0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("t5_no_rsp", rsp0_valid, 1'b0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'hD0; req1_addr = 32'hE0; #1;
        check1("t5_req0_wins", req0_ready, 1'b1);
        check1("t5_req1_loses", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; mem_ready = 1'b1; mem_read_data = 32'h5A;
        tick();
        // spurious ready during the response cycle
        #1;
        check1("t6_rsp_pulse", rsp0_valid, 1'b1);
        tick(); #1;
        check1("t6_no_extra", rsp0_valid, 1'b0);
        check1("t6_busy", busy, 1'b0);
        mem_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares one data-memory port between two requesters: port 0 is the core datapath, port 1 is a secondary master (DMA or debug loader).
- Accepts one transaction at a time and drives the memory-side valid/ready handshake.
- Returns a single-cycle response pulse to the owning requester.
- Arbitration is round-robin; an optional timeout aborts stalled accesses and flags an error.

Parameters:
ADDR_SIZE, 32, address width of requester and memory ports
DATA_SIZE, 32, data width of requester and memory ports
TIMEOUT_CYCLES, 64, max ACCESS cycles waiting for mem_ready before abort; 0 disables timeout

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 request accepted this cycle
req0_addr  in  ADDR_SIZE  port 0 address
req0_write_enable  in  1  port 0 write (1) / read (0)
req0_write_data  in  DATA_SIZE  port 0 write data
rsp0_valid  out  1  port 0 response pulse
rsp0_read_data  out  DATA_SIZE  port 0 read result
rsp0_error  out  1  port 0 transaction timed out
req1_valid, req1_ready, req1_addr, req1_write_enable, req1_write_data, rsp1_valid, rsp1_read_data, rsp1_error: same as port 0, for port 1
mem_addr  out  ADDR_SIZE  memory address
mem_write_enable  out  1  memory write strobe, qualified by mem_valid
mem_write_data  out  DATA_SIZE  memory write data
mem_valid  out  1  memory access request
mem_ready  in  1  memory completes access this cycle
mem_read_data  in  DATA_SIZE  memory read data, valid with mem_ready
busy  out  1  state != IDLE
grant  out  1  index of current/last owner

Behaviour:
- Reset (rst low, async): state IDLE, priority pointer = 0 (port 0 favoured), timeout counter 0, grant 0.
- Reset values: all outputs 0, including latched mem_addr/mem_write_enable/mem_write_data and rsp data.
- Reset mid-transaction abandons it: no response is issued, mem_valid drops immediately.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - If any reqN_valid, select a winner. If both are valid, the port equal to the pointer wins; otherwise the single valid port wins.
  - reqN_ready is combinational, high only for the winner, only in IDLE.
  - On the accept edge, latch addr/write_enable/write_data into the mem_* registers, set grant, clear the counter, go to ACCESS.
- ACCESS:
  - mem_valid=1; mem_* stay stable until the handshake.
  - On mem_valid && mem_ready: capture mem_read_data for reads (0 for writes), error=0, go to RESPOND.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without mem_ready: drop mem_valid next cycle, error=1, data=0, go to RESPOND.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- RESPOND:
  - rspN_valid=1 for exactly one cycle on the granted port, with rspN_read_data/rspN_error. No backpressure.
  - Other-port rsp signals stay 0.
  - Pointer becomes the non-granted port. Go to IDLE.
- Latency: accept at cycle T, mem_valid high at T+1. With mem_ready at T+1, rsp_valid is high at T+2. The next accept is possible at T+3 (throughput 1 transaction per 3 cycles minimum).
- rsp data registers hold their value after the pulse until the next response to that port.
- mem_ready outside ACCESS is ignored.
- Requesters must hold req fields stable while valid until ready; no checking is done.
- mem_valid is never asserted in IDLE or RESPOND. Only one transaction is ever outstanding.

Test Plan:
- Single read port 0: req0 addr=0x60, we=0. mem_ready at the first ACCESS cycle with read_data=0x19 -> req0_ready at T, mem_valid/mem_addr=0x60 at T+1, rsp0_valid=1 with data 0x19 at T+2, rsp1_valid stays 0.
- Write port 1 with 3 wait cycles: addr=0x64, wdata=25 -> mem_valid held 4 cycles with stable fields; rsp1_valid one cycle after mem_ready with error=0, data=0.
- Contention: both ports request continuously after reset -> grant order 0,1,0,1. Each accept is 3 cycles apart when memory is zero-wait.
- Timeout with TIMEOUT_CYCLES=4, mem_ready tied low -> mem_valid high exactly 4 cycles, then rsp0_valid=1, rsp0_error=1, data=0. Arbiter returns to IDLE and accepts the next request.
- Async reset asserted during ACCESS -> mem_valid, busy, rsp* go 0 immediately. No response for the aborted request; after release, port 0 wins a simultaneous request.
- Spurious mem_ready in IDLE and RESPOND -> no state change, no extra rsp pulse.
